// File: rtl/tile_pkg.sv
// Shared tile geometry, tile array type and assembler state encoding.
package tile_pkg;

  localparam int TILE_ROWS  = 8;
  localparam int TILE_COLS  = 16;
  localparam int TILE_ELEMS = TILE_ROWS * TILE_COLS;
  localparam int TILE_IDX_W = $clog2(TILE_ELEMS);

  typedef logic [0:TILE_ROWS-1][0:TILE_COLS-1][7:0] tile_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } tile_asm_state_e;

endpackage

// File: rtl/tile_stream_assembler.sv
// Assembles a row-major byte stream into a parallel tile plus tag and
// presents it downstream on a valid/ready handshake, flagging framing errors.
module tile_stream_assembler
  import tile_pkg::*;
#(
  parameter int ROWS   = TILE_ROWS,
  parameter int COLS   = TILE_COLS,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [DATA_W-1:0]                      s_data,
  input  logic [TAG_W-1:0]                       s_tag,
  input  logic                                   s_last,
  output logic [0:ROWS-1][0:COLS-1][DATA_W-1:0]  tile_data,
  output logic [TAG_W-1:0]                       tile_tag,
  output logic                                   tile_valid,
  input  logic                                   tile_ready,
  output logic                                   err_frame
);

  localparam int IDX_W = $clog2(ROWS * COLS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS * COLS - 1);

  tile_asm_state_e r_state;
  tile_asm_state_e w_nextState;

  logic [IDX_W-1:0]                      r_cnt;
  logic [0:ROWS-1][0:COLS-1][DATA_W-1:0] r_tile;
  logic [TAG_W-1:0]                      r_tag;
  logic                                  r_err;

  logic                   w_accept;
  logic                   w_isLastIdx;
  logic                   w_short;
  logic                   w_long;
  logic [IDX_W-COL_W-1:0] w_row;
  logic [COL_W-1:0]       w_col;

  assign w_accept    = s_valid & s_ready;
  assign w_isLastIdx = (r_cnt == LAST_IDX);
  assign w_row       = r_cnt[IDX_W-1:COL_W];
  assign w_col       = r_cnt[COL_W-1:0];
  assign w_short     = w_accept & s_last & ~w_isLastIdx;
  assign w_long      = w_accept & ~s_last & w_isLastIdx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A short tile drops straight back to IDLE; the final index always completes.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isLastIdx) w_nextState = HOLD;
          else if (s_last) w_nextState = IDLE;
          else             w_nextState = FILL;
        end
      end
      FILL: begin
        if (w_accept) begin
          if (w_isLastIdx) w_nextState = HOLD;
          else if (s_last) w_nextState = IDLE;
        end
      end
      HOLD: begin
        if (tile_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = 1'b1;
    tile_valid = 1'b0;
    if (r_state == HOLD) begin
      s_ready    = 1'b0;
      tile_valid = 1'b1;
    end
  end

  // Byte writes and tag capture; the tag is only taken on the first byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tile <= '0;
      r_tag  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_short | w_long;
      if (w_accept) begin
        r_tile[w_row][w_col] <= s_data;
        if (r_state == IDLE) r_tag <= s_tag;
        if (s_last || w_isLastIdx) r_cnt <= '0;
        else                       r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tile_data = r_tile;
  assign tile_tag  = r_tag;
  assign err_frame = r_err;

endmodule

// File: tb/tb_tile_stream_assembler.sv
// Directed bench for tile_stream_assembler: table of tile scenarios plus a
// hand-written asynchronous reset sequence.
module tb_tile_stream_assembler;
  import tile_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] tag;
    logic [7:0]  base;
    int          lastAt;
    bit          gapped;
    int          hold;
    bit          expTile;
    bit          expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sValid = 1'b0;
  logic        sReady;
  logic [7:0]  sData = '0;
  logic [15:0] sTag = '0;
  logic        sLast = 1'b0;
  tile_t       tileData;
  logic [15:0] tileTag;
  logic        tileValid;
  logic        tileReady = 1'b0;
  logic        errFrame;

  int    nComp = 0;
  int    nFail = 0;
  tile_t expT;
  tile_t zeroT;
  vec_t  vecs[7];

  tile_stream_assembler dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (sValid),
    .s_ready    (sReady),
    .s_data     (sData),
    .s_tag      (sTag),
    .s_last     (sLast),
    .tile_data  (tileData),
    .tile_tag   (tileTag),
    .tile_valid (tileValid),
    .tile_ready (tileReady),
    .err_frame  (errFrame)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic checkTile(input string name, input tile_t exp);
    int badR = -1;
    int badC = -1;
    for (int r = 0; r < TILE_ROWS; r++)
      for (int c = 0; c < TILE_COLS; c++)
        if (badR < 0 && tileData[r][c] !== exp[r][c]) begin
          badR = r;
          badC = c;
        end
    nComp++;
    if (badR >= 0) begin
      nFail++;
      $display("[TB] FAIL %s: element [%0d][%0d] got %0h, required %0h",
               name, badR, badC, tileData[badR][badC], exp[badR][badC]);
    end
  endtask

  task automatic sendByte(input logic [7:0] d, input logic [15:0] t, input bit l, input int gap);
    int guard = 0;
    sValid = 1'b0;
    repeat (gap) @(negedge clk);
    sValid = 1'b1;
    sData  = d;
    sTag   = t;
    sLast  = l;
    while (!sReady && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!sReady) begin
      nComp++;
      nFail++;
      $display("[TB] FAIL accept timeout: got s_ready 0, required 1");
    end
    @(negedge clk);
    sValid = 1'b0;
    sLast  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    logic [7:0] d;
    n = (v.lastAt >= 0 && v.lastAt < TILE_ELEMS - 1) ? v.lastAt + 1 : TILE_ELEMS;
    tileReady = (v.hold == 0);
    for (int i = 0; i < n; i++) begin
      d = v.base + 8'(i);
      if (i == n - 1) checkOutput({v.name, " valid before last"}, 32'(tileValid), 32'd0);
      sendByte(d, (i == 0) ? v.tag : (16'hDEAD ^ 16'(i)), (i == v.lastAt),
               v.gapped ? int'($urandom_range(0, 1)) : 0);
      expT[i / TILE_COLS][i % TILE_COLS] = d;
    end
    checkOutput({v.name, " err_frame"}, 32'(errFrame), 32'(v.expErr));
    checkOutput({v.name, " tile_valid"}, 32'(tileValid), 32'(v.expTile));
    if (v.expTile) begin
      checkOutput({v.name, " s_ready in hold"}, 32'(sReady), 32'd0);
      checkTile({v.name, " tile_data"}, expT);
      checkOutput({v.name, " tile_tag"}, 32'(tileTag), 32'(v.tag));
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clk);
        checkOutput({v.name, " hold valid"}, 32'(tileValid), 32'd1);
        checkOutput({v.name, " hold s_ready"}, 32'(sReady), 32'd0);
        checkOutput({v.name, " hold tag"}, 32'(tileTag), 32'(v.tag));
        checkTile({v.name, " hold data"}, expT);
      end
      tileReady = 1'b1;
    end
    @(negedge clk);
    checkOutput({v.name, " valid after"}, 32'(tileValid), 32'd0);
    checkOutput({v.name, " s_ready after"}, 32'(sReady), 32'd1);
    checkOutput({v.name, " err single pulse"}, 32'(errFrame), 32'd0);
  endtask

  initial begin
    zeroT = '0;
    expT  = '0;
    vecs[0] = '{"single",   16'hA5C3, 8'h00, 127, 1'b0, 0,  1'b1, 1'b0};
    vecs[1] = '{"backpres", 16'h0002, 8'h80, 127, 1'b0, 20, 1'b1, 1'b0};
    vecs[2] = '{"short",    16'h1111, 8'h40, 40,  1'b0, 0,  1'b0, 1'b1};
    vecs[3] = '{"aftshort", 16'h2222, 8'h10, 127, 1'b0, 0,  1'b1, 1'b0};
    vecs[4] = '{"long",     16'h4444, 8'h20, -1,  1'b0, 0,  1'b1, 1'b1};
    vecs[5] = '{"aftlong",  16'h3333, 8'h5A, 127, 1'b0, 0,  1'b1, 1'b0};
    vecs[6] = '{"gapped",   16'hA5C3, 8'h00, 127, 1'b1, 0,  1'b1, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset s_ready", 32'(sReady), 32'd1);
    checkOutput("reset tile_valid", 32'(tileValid), 32'd0);
    checkOutput("reset err_frame", 32'(errFrame), 32'd0);
    checkOutput("reset tile_tag", 32'(tileTag), 32'd0);
    checkTile("reset tile_data", zeroT);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) applyStimulus(vecs[v]);

    // Reset in the middle of a fill must wipe everything without a clock edge.
    tileReady = 1'b1;
    for (int i = 0; i < 64; i++)
      sendByte(8'(i) ^ 8'hFF, 16'h7777, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst tile_valid", 32'(tileValid), 32'd0);
    checkOutput("midrst s_ready", 32'(sReady), 32'd1);
    checkOutput("midrst err_frame", 32'(errFrame), 32'd0);
    checkOutput("midrst tile_tag", 32'(tileTag), 32'd0);
    checkTile("midrst tile_data", zeroT);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus('{"postrst", 16'h4242, 8'h33, 127, 1'b0, 0, 1'b1, 1'b0});
    repeat (4) @(negedge clk);
    checkOutput("postrst no extra tile", 32'(tileValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule

// File: doc/tile_stream_assembler.md
# tile_stream_assembler

Inbound counterpart of the tile-consuming compute stage: accepts a row-major byte stream over a valid/ready handshake and assembles it into a parallel 8×16 byte tile with a 16-bit tag. It presents the tile downstream on its own valid/ready handshake. It sits between the DMA/byte-stream front end and any block that takes a full `[7:0] [0:7][0:15]` tile plus a 16-bit side word and a 1-bit strobe.

## Interface
- `ROWS`, 8, tile rows.
- `COLS`, 16, tile columns; `ROWS*COLS` must be a power of two.
- `DATA_W`, 8, element width.
- `TAG_W`, 16, tag width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  1  stream byte valid.
- `s_ready`  out  1  stream byte accepted when `s_valid & s_ready`.
- `s_data`  in  DATA_W  stream byte.
- `s_tag`  in  TAG_W  tag; sampled only on the first byte of a tile.
- `s_last`  in  1  marks the final byte of a tile.
- `tile_data`  out  DATA_W × [0:ROWS-1][0:COLS-1]  assembled tile.
- `tile_tag`  out  TAG_W  tag of the presented tile.
- `tile_valid`  out  1  tile available.
- `tile_ready`  in  1  downstream accepts when `tile_valid & tile_ready`.
- `err_frame`  out  1  one-cycle pulse on a framing error.

## Operation
- States:
  - IDLE: no partial tile.
  - FILL: partial tile in progress.
  - HOLD: full tile presented.
- Index counter `cnt` is log2(ROWS*COLS) bits (7). Row is `cnt[6:4]` and column is `cnt[3:0]`. Each accepted byte is written to `tile_data[row][col]`, then `cnt` increments.
- IDLE:
  - `s_ready=1`.
  - On accept: capture `s_tag` into `tile_tag`, write element [0][0], set `cnt=1`, go to FILL.
- FILL:
  - `s_ready=1`.
  - On accept of byte 127 (`cnt==127`): go to HOLD and wrap `cnt` to 0.
- HOLD:
  - `s_ready=0` and `tile_valid=1`.
  - On `tile_ready`: go to IDLE, drop `tile_valid`.
  - `tile_data` and `tile_tag` stay stable throughout HOLD.
- Framing rules:
  - `s_last=1` on an accepted byte with `cnt<127` (short tile): discard the partial tile, set `cnt=0`, return to IDLE, pulse `err_frame`. No tile is presented.
  - `s_last=0` on byte 127 (long tile): the tile still completes to HOLD and `err_frame` pulses. The following byte starts a new tile.
  - `s_last=1` on byte 127: normal completion, no error.
  - A single-byte tile (`s_last` on the first byte) is a short tile and takes the short-tile path.
- `s_tag` is ignored on bytes 1..127.

## Timing
- Reset values:
  - `s_ready=1`, `tile_valid=0`, `err_frame=0`.
  - `tile_data` all 0, `tile_tag=0`.
  - `cnt=0`, state IDLE.
- Reset asserted mid-FILL or mid-HOLD discards all tile state immediately (asynchronously). No tile is emitted for that data.
- Latency: `tile_valid` rises the cycle after the 128th byte is accepted.
- `err_frame` is registered and pulses the cycle after the offending byte is accepted.
- `s_ready` is a registered function of state. It is 0 for the entire HOLD period, including the cycle in which `tile_ready` is sampled high. It returns to 1 the cycle after the tile handshake.
- Throughput with back-to-back streaming and `tile_ready` held high: 128 accept cycles plus 1 HOLD cycle, i.e. 129 cycles per tile.
- `tile_valid` never drops without a handshake (except on reset). `tile_ready` is ignored outside HOLD.

## Structure
- Shared package `tile_pkg` holds:
  - `TILE_ROWS=8`, `TILE_COLS=16`, `TILE_ELEMS=128`, `TILE_IDX_W=7`;
  - `tile_t` (the `[7:0] [0:7][0:15]` array type);
  - the state enum `tile_asm_state_e {IDLE, FILL, HOLD}`.
- No sub-module: the counter, write decode and FSM stay in one module (roughly 150–250 lines).

## Test plan
- **Single tile:** stream bytes 0x00..0x7F with `s_tag=0xA5C3` on byte 0, `s_last` on byte 127, `tile_ready=1`.
  - Expect `tile_valid` one cycle after the last accept.
  - Expect `tile_data[r][c]==16*r+c` and `tile_tag==0xA5C3`.
  - Expect `err_frame` to stay 0.
- **Backpressure:** `tile_ready=0` for 20 cycles after completion.
  - `tile_valid` and the contents stay stable, and `s_ready=0` throughout.
  - After `tile_ready=1`, `s_ready=1` the next cycle; the second tile is assembled correctly with tag 0x0002.
- **Short tile:** assert `s_last` on byte 40.
  - `err_frame` pulses once and no `tile_valid` is produced.
  - A following full 128-byte tile is emitted with its own tag.
- **Long tile:** omit `s_last` on byte 127.
  - The tile is emitted and `err_frame` pulses once.
  - The 129th byte becomes element [0][0] of the next tile.
- **Reset mid-fill:** pulse `rst` after 64 bytes.
  - All outputs return to their reset values asynchronously.
  - A fresh 128-byte stream then produces exactly one correct tile.
- **Gapped stream:** drive `s_valid` randomly at 50% duty.
  - The tile is identical to the one in the first scenario; only the latency changes.
